// File: rtl/adc_top.sv
// Serial-ADC frame controller: drives conv/ADCclk/ADC_in to an AD79xx-class converter
// and assembles the returned serial result into a parallel word with a done strobe.
module adc_top #(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned GAP       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              I1,
    input  logic              I2,
    input  logic              I3,
    input  logic              ADC_out,
    output logic              conv,
    output logic              ADCclk,
    output logic              ADC_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [DivW-1:0] DivLast      = DivW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast      = BitW'(FRAME_LEN - 1);
    localparam logic [BitW-1:0] BitFirstData = BitW'(FRAME_LEN - DATA_W);
    localparam logic [GapW-1:0] GapLast      = GapW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {StIdle, StFrame, StDone, StWait} state_e;

    state_e              state_q, state_d;
    logic [DivW-1:0]     div_cnt_q, div_cnt_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [ADDR_W-1:0]   addr_sr_q, addr_sr_d;
    logic [DATA_W-1:0]   data_sr_q, data_sr_d;
    logic                conv_q, conv_d;
    logic                adcclk_q, adcclk_d;
    logic                adc_in_q, adc_in_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;

    logic                half_end;
    logic                last_fall;
    logic                start;
    logic [ADDR_W-1:0]   addr_in;
    logic [ADDR_W-1:0]   addr_next;
    logic [DATA_W-1:0]   data_next;
    logic [DATA_W-1:0]   data_shift;

    assign addr_in    = ADDR_W'({I3, I2, I1});
    assign addr_next  = addr_sr_q << 1;
    assign data_next  = (data_sr_q << 1) | DATA_W'(ADC_out);
    // Early samples (leading zeros / tracking bits) are not part of the result.
    assign data_shift = (bit_cnt_q >= BitFirstData) ? data_next : data_sr_q;
    assign half_end   = (state_q == StFrame) && (div_cnt_q == DivLast);
    assign last_fall  = half_end && adcclk_q && (bit_cnt_q == BitLast);
    assign start      = (state_d == StFrame) && (state_q != StFrame);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            addr_sr_q  <= '0;
            data_sr_q  <= '0;
            conv_q     <= 1'b0;
            adcclk_q   <= 1'b0;
            adc_in_q   <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            addr_sr_q  <= addr_sr_d;
            data_sr_q  <= data_sr_d;
            conv_q     <= conv_d;
            adcclk_q   <= adcclk_d;
            adc_in_q   <= adc_in_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StFrame;
            StFrame: if (last_fall) state_d = StDone;
            StDone: begin
                if (GAP == 0) state_d = enable ? StFrame : StIdle;
                else          state_d = StWait;
            end
            StWait:  if (gap_cnt_q == GapLast) state_d = enable ? StFrame : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = '0;
        addr_sr_d  = addr_sr_q;
        data_sr_d  = data_sr_q;
        conv_d     = 1'b0;
        adcclk_d   = 1'b0;
        adc_in_d   = 1'b0;
        done_d     = 1'b0;
        data_out_d = data_out_q;

        case (state_q)
            StFrame: begin
                conv_d   = 1'b1;
                adcclk_d = adcclk_q;
                adc_in_d = adc_in_q;
                if (half_end) begin
                    div_cnt_d = '0;
                    adcclk_d  = ~adcclk_q;
                    if (adcclk_q) begin
                        // Falling edge: next address bit out, current data bit in.
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        addr_sr_d = addr_next;
                        adc_in_d  = addr_next[ADDR_W-1];
                        data_sr_d = data_shift;
                        if (last_fall) begin
                            conv_d     = 1'b0;
                            adc_in_d   = 1'b0;
                            done_d     = 1'b1;
                            data_out_d = data_shift;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StWait:  gap_cnt_d = gap_cnt_q + 1'b1;
            default: ;
        endcase

        if (start) begin
            conv_d    = 1'b1;
            adcclk_d  = 1'b0;
            adc_in_d  = addr_in[ADDR_W-1];
            addr_sr_d = addr_in;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            data_sr_d = '0;
        end
    end

    assign conv     = conv_q;
    assign ADCclk   = adcclk_q;
    assign ADC_in   = adc_in_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_adc_top.sv
// Bench for adc_top: a converter model answers ADCclk, frames are checked against
// per-cycle address/data expectations derived from the frame rules.
module tb_adc_top;

    localparam int LAT    = 33;
    localparam int PERIOD = 35;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       I1, I2, I3;
    logic       ADC_out;
    logic       conv;
    logic       ADCclk;
    logic       ADC_in;
    logic [9:0] data_out;
    logic       done;

    int n_total;
    int n_pass;
    int n_fail;

    // Converter model state.
    logic [15:0] pattern;
    logic [15:0] seen_in;
    int          k;
    int          pulses;
    int          unstable;
    int          glitch;
    logic        prev_clk;
    logic        prev_conv;

    adc_top dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .I1       (I1),
        .I2       (I2),
        .I3       (I3),
        .ADC_out  (ADC_out),
        .conv     (conv),
        .ADCclk   (ADCclk),
        .ADC_in   (ADC_in),
        .data_out (data_out),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Converter: counts ADCclk cycles, records DIN on each rising edge, drives DOUT.
    initial begin
        k = 0; pulses = 0; unstable = 0; glitch = 0;
        seen_in = '0; prev_clk = 1'b0; prev_conv = 1'b0; ADC_out = 1'b0;
        forever begin
            @(negedge clk);
            if (conv && !prev_conv) begin
                k = 0; seen_in = '0; pulses = 0;
            end else if (conv && prev_clk && !ADCclk) begin
                k++;
            end
            if (conv && ADCclk && !prev_clk && k < 16) begin
                pulses++;
                seen_in[15-k] = ADC_in;
            end else if (conv && ADCclk && prev_clk && k < 16 && ADC_in !== seen_in[15-k]) begin
                unstable++;
            end
            if (!conv && ADCclk) glitch++;
            ADC_out = (conv && k < 16) ? pattern[15-k] : 1'b0;
            prev_clk  = ADCclk;
            prev_conv = conv;
        end
    end

    // Expected DIN per ADCclk cycle (bit 15 = cycle 0): address MSB first, then zeros.
    function automatic logic [15:0] model_din(input logic [2:0] a);
        logic [15:0] r;
        for (int c = 0; c < 16; c++) r[15-c] = (c < 3) ? a[2-c] : 1'b0;
        return r;
    endfunction

    // Expected result: the samples of the last ten ADCclk cycles, first one is the MSB.
    function automatic logic [9:0] model_data(input logic [15:0] p);
        logic [9:0] r;
        r = '0;
        for (int c = 6; c < 16; c++) r = {r[8:0], p[15-c]};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit drop, input int budget, output int cyc, output bit found);
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (drop && cyc == 1) enable = 1'b0;
            if (done === 1'b1) found = 1'b1;
        end
    endtask

    task automatic wait_k(input string tag, input int target);
        int cnt;
        cnt = 0;
        while (k != target && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_reach_cycle"}, 32'(k == target), 32'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (conv !== 1'b0 || done !== 1'b0 || ADCclk !== 1'b0) bad++;
        end
        check({tag, "_no_new_frame"}, bad, 0);
    endtask

    task automatic frame_checks(input string tag, input logic [2:0] a, input logic [15:0] p);
        logic [9:0] held;
        check({tag, "_data"}, data_out, model_data(p));
        check({tag, "_conv_low"}, conv, 0);
        check({tag, "_din"}, seen_in, model_din(a));
        check({tag, "_pulses"}, pulses, 16);
        check({tag, "_din_stable"}, unstable, 0);
        held = data_out;
        @(negedge clk);
        check({tag, "_done_1cyc"}, done, 0);
        check({tag, "_hold"}, data_out, held);
    endtask

    task automatic run_frame(input string tag, input logic [2:0] a, input logic [15:0] p);
        int  cyc;
        bit  found;
        {I3, I2, I1} = a;
        pattern = p;
        @(negedge clk);
        enable = 1'b1;
        wait_done(1'b1, 100, cyc, found);
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        check({tag, "_latency"}, cyc, LAT);
        frame_checks(tag, a, p);
    endtask

    initial begin
        int          cyc;
        bit          found;
        int          bad;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [15:0] p;

        n_total = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1; enable = 1'b0; I1 = 1'b0; I2 = 1'b0; I3 = 1'b0; pattern = '0;

        // Reset and idle
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_conv", conv, 0);
        check("rst_adcclk", ADCclk, 0);
        check("rst_adc_in", ADC_in, 0);
        check("rst_done", done, 0);
        check("rst_data", data_out, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (conv | ADCclk | ADC_in | done | (data_out != 0)) bad++;
        end
        check("idle_quiet", bad, 0);

        // Address shift and data capture
        run_frame("addr101", 3'b101, 16'($urandom));
        run_frame("data2b5", 3'($urandom), {6'h3F, 10'h2B5});

        // Random frames
        for (int n = 0; n < 4; n++) begin
            run_frame($sformatf("rand%0d", n), 3'($urandom), 16'($urandom));
        end

        // Continuous mode, alternating full-scale and zero results
        {I3, I2, I1} = 3'($urandom);
        a = {I3, I2, I1};
        pattern = {6'($urandom), 10'h3FF};
        @(negedge clk);
        enable = 1'b1;
        wait_done(1'b0, 100, cyc, found);
        check("cont0_latency", cyc, LAT);
        check("cont0_data", data_out, 10'h3FF);
        for (int n = 1; n <= 4; n++) begin
            p = (n % 2 == 1) ? {6'($urandom), 10'h000} : {6'($urandom), 10'h3FF};
            pattern = p;
            wait_done(1'b0, 100, cyc, found);
            check($sformatf("cont%0d_period", n), cyc, PERIOD);
            check($sformatf("cont%0d_data", n), data_out, model_data(p));
            check($sformatf("cont%0d_din", n), seen_in, model_din(a));
        end
        enable = 1'b0;
        quiet("cont_stop", 40);

        // Drop enable mid-frame: frame completes, nothing follows
        a = 3'($urandom);
        p = 16'($urandom) | 16'h0001;
        {I3, I2, I1} = a;
        pattern = p;
        @(negedge clk);
        enable = 1'b1;
        wait_k("drop_en", 4);
        enable = 1'b0;
        wait_done(1'b0, 100, cyc, found);
        check("drop_en_done_seen", 32'(found), 32'd1);
        frame_checks("drop_en", a, p);
        quiet("drop_en", 40);

        // Reset mid-frame: abort, outputs and result cleared, no done
        {I3, I2, I1} = 3'($urandom);
        pattern = 16'($urandom);
        @(negedge clk);
        enable = 1'b1;
        wait_k("mid_rst", 8);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("mid_rst_conv", conv, 0);
        check("mid_rst_adcclk", ADCclk, 0);
        check("mid_rst_adc_in", ADC_in, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_data", data_out, 0);
        rst = 1'b0;
        quiet("mid_rst", 40);

        // Address changes mid-frame are ignored until the next frame
        a = 3'($urandom);
        b = ~a;
        p = 16'($urandom);
        {I3, I2, I1} = a;
        pattern = p;
        @(negedge clk);
        enable = 1'b1;
        wait_k("addr_latch", 1);
        enable = 1'b0;
        {I3, I2, I1} = b;
        wait_done(1'b0, 100, cyc, found);
        check("addr_latch_done_seen", 32'(found), 32'd1);
        frame_checks("addr_latch", a, p);
        run_frame("addr_new", b, 16'($urandom));

        check("adcclk_only_in_frame", glitch, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_top.md
# adc_top

Serial-ADC interface controller for 10-bit SPI-style converters with a 3-bit channel address (AD79xx class). It generates the conversion frame strobe and serial clock, and shifts the channel address out to the converter. It also shifts the conversion result back in and presents it as a parallel word with a one-cycle `done` strobe. It sits between the converter pins and system logic; one frame runs per request while `enable` is high.

## Interface

Parameters:
- `DATA_W`, default 10: result width.
- `ADDR_W`, default 3: channel address width.
- `FRAME_LEN`, default 16: ADCclk cycles per frame; must be ≥ `ADDR_W` and ≥ `DATA_W`.
- `CLK_DIV`, default 1: `clk` cycles per ADCclk half-period; must be ≥ 1.
- `GAP`, default 2: idle `clk` cycles between frames (quiet time).

Ports:
- `clk`  in  1: single system clock; all logic is on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `enable`  in  1: run request; level-sensitive.
- `I1`, `I2`, `I3`  in  1 each: channel address; `I3` is the MSB.
- `ADC_out`  in  1: serial data from the converter (its DOUT).
- `conv`  out  1: frame strobe; high for the whole frame.
- `ADCclk`  out  1: serial clock to the converter; idles low.
- `ADC_in`  out  1: serial data to the converter (its DIN).
- `data_out`  out  10: last completed result.
- `done`  out  1: one-cycle pulse when `data_out` updates.

## Operation

- **Reset values:** `conv`=0, `ADCclk`=0, `ADC_in`=0, `done`=0, `data_out`=0. The FSM is in IDLE and all counters and shift registers are 0.
- **FSM states:** IDLE → FRAME → DONE → WAIT → (FRAME or IDLE).
- **IDLE:** when `enable`=1, go to FRAME on the next edge. On that edge:
  - latch `{I3,I2,I1}` into the address shift register;
  - set `conv`=1;
  - drive `ADC_in` = `I3`.
- **FRAME:** `ADCclk` alternates CLK_DIV cycles low, then CLK_DIV cycles high, `FRAME_LEN` times. Each high→low transition is the falling edge.
- **Address out:**
  - `ADC_in` presents address bits MSB first, one per ADCclk cycle, changing only on falling edges.
  - During ADCclk cycles 0..ADDR_W-1 it carries `I3`, `I2`, `I1`; after that it is 0.
- **Data in:**
  - `ADC_out` is sampled on the `clk` edge that produces each falling edge.
  - Samples from ADCclk cycles FRAME_LEN-DATA_W .. FRAME_LEN-1 (cycles 6..15 by default) are shifted in MSB first.
  - Earlier samples (leading zeros or tracking bits) are discarded.
- **End of frame:** on the `clk` edge of the final falling edge, go to DONE:
  - `conv`=0;
  - `data_out` ← assembled word;
  - `done`=1 for exactly one cycle.
- **WAIT:** hold all outputs idle for `GAP` cycles, then go to FRAME if `enable`=1, otherwise IDLE.
- **`enable`:** it is only checked in IDLE and at the end of WAIT. Dropping it mid-frame does not abort; the frame completes with a normal `done`.
- **Address changes:** the address is latched only at frame start; `I1`–`I3` changing mid-frame has no effect.
- **Reset mid-frame:** aborts the frame. All outputs return to reset values on that edge, `data_out` is cleared, and `done` does not fire.
- **`data_out` hold:** it keeps its value between `done` pulses.

## Timing

- Frame length is 2·CLK_DIV·FRAME_LEN `clk` cycles (32 by default), measured from the edge that raises `conv` to the edge that drops it.
- Latency from `enable` sampled high in IDLE to `done`=1 is 1 + 2·CLK_DIV·FRAME_LEN cycles (33 by default).
- With `enable` held high, frames repeat every 2·CLK_DIV·FRAME_LEN + 1 + GAP cycles (35 by default).
- `done` is coincident with `data_out` update and `conv` fall.
- `ADCclk` is a registered output with no glitches, and it is 0 whenever `conv`=0.
- `ADC_in` is registered and stable for the whole high phase of `ADCclk`.

## Test plan

1. **Reset and idle:** assert `rst` with `enable`=0 for 5 cycles, then release. Required: all outputs stay 0 for 20 cycles.
2. **Address shift:** {I3,I2,I1}=3'b101, then pulse `enable` for 1 cycle. Required:
   - `ADC_in` reads 1,0,1 across ADCclk cycles 0–2 and 0 for cycles 3–15;
   - exactly 16 ADCclk pulses occur while `conv`=1.
3. **Data capture:** a converter model drives 10'h2B5 MSB first, one bit per ADCclk cycle, in cycles 6–15, with 1s in cycles 0–5. Required: `data_out`=10'h2B5 and `done`=1 for one cycle, 33 cycles after start.
4. **Continuous mode:** hold `enable`=1 and send data alternating 10'h3FF and 10'h000. Required: `done` every 35 cycles, with `data_out` alternating accordingly.
5. **Mid-frame events:**
   - drop `enable` at ADCclk cycle 4: the frame completes with `done` and no new frame starts;
   - in a separate run, assert `rst` at ADCclk cycle 8: outputs are 0 on the next cycle, no `done`, and `data_out`=0.
6. **Address latch:** change `I1`–`I3` mid-frame. Required: `ADC_in` still carries the address latched at frame start; the new address appears only in the next frame.
